// File: rtl/mips_mem_pkg.sv
// Shared definitions for the data-memory responder:
// word width, FSM encoding and the address fault check.
package mips_mem_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // Faults on misalignment or any set bit above the array range.
  // aw is the bit position of the first out-of-range address bit.
  function automatic logic is_fault(
    input logic [WORD_W-1:0] a,
    input int unsigned       aw
  );
    return (a[1:0] != 2'b00) || ((a >> aw) != '0);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port word array with byte write enables.
// Writes are synchronous, reads are combinational.
module dmem_array
  import mips_mem_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [3:0]        be_i,
  input  logic [AW-1:0]     idx_i,
  input  logic [WORD_W-1:0] wdata_i,
  output logic [WORD_W-1:0] rdata_o
);

  logic [WORD_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int i = 0; i < 4; i++) begin
        if (be_i[i]) begin
          mem_q[idx_i][8*i +: 8] <= wdata_i[8*i +: 8];
        end
      end
    end
  end

  assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/data_mem_responder.sv
// Wait-state data memory responder: accepts one request,
// inserts WAIT_CYCLES wait states, then acks for one cycle.
module data_mem_responder
  import mips_mem_pkg::*;
#(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  input  logic [3:0]        be,
  output logic              busy,
  output logic              ack,
  output logic [31:0]       rdata,
  output logic              err
);

  localparam int          AW  = $clog2(DEPTH);
  localparam logic [3:0]  WC4 = 4'(WAIT_CYCLES);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              we_q;
  logic [31:0]       addr_q;
  logic [31:0]       wdata_q;
  logic [3:0]        be_q;
  logic              accept;
  logic              fault;
  logic              mem_we;
  logic [WORD_W-1:0] mem_rdata;

  assign accept = (state_q == IDLE) && req;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        we_q    <= we;
        addr_q  <= addr;
        wdata_q <= wdata;
        be_q    <= be;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          cnt_d   = WC4;
          state_d = (WAIT_CYCLES > 0) ? WAIT : RESP;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = RESP;
      end
      RESP: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // A reset in the ack cycle suppresses both ack and the store.
  always_comb begin
    fault  = is_fault(addr_q, AW + 2);
    busy   = (state_q != IDLE);
    ack    = (state_q == RESP) && !rst;
    err    = ack && fault;
    mem_we = ack && we_q && !fault;
    rdata  = '0;
    if (ack && !we_q && !fault) rdata = mem_rdata;
  end

  dmem_array #(
    .DEPTH (DEPTH)
  ) u_array (
    .clk_i   (clk),
    .we_i    (mem_we),
    .be_i    (be_q),
    .idx_i   (addr_q[AW+1:2]),
    .wdata_i (wdata_q),
    .rdata_o (mem_rdata)
  );

endmodule
